// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg -- shared AES definitions for the key schedule and round datapath.
//   AES_ROUNDS  : number of AES-128 rounds (10)
//   AES_RCON    : round constants for rounds 1..10
//   aes_block_t : 128-bit block / round-key type
//   ke_state_t  : key-expansion FSM state type
//   aes_rcon()  : Rcon lookup; returns 0 outside rounds 1..10
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [3:0] AES_ROUNDS = 4'd10;

    // Element [n] is the round constant used to derive round key n.
    localparam logic [10:1][7:0] AES_RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    typedef logic [127:0] aes_block_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ke_state_t;

    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] rc;
        if ((round >= 4'd1) && (round <= AES_ROUNDS)) begin
            rc = AES_RCON[round];
        end else begin
            rc = 8'h00;
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ----------------------------------------------------------------------------
// aes_sbox -- single-byte combinational AES S-box.
// Computes the multiplicative inverse in GF(2^8) (x^254, so 0 maps to 0)
// followed by the FIPS-197 affine transform. Usable by both the key schedule
// and the SubBytes stage.
// Ports:
//   value        in  8  byte to substitute
//   substituted  out 8  S-box output
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] substituted
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? aa : 8'h00);
            aa  = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as x^2 * x^4 * ... * x^128 = x^254.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] res;
        pw  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            res = gf_mul(res, pw);
        end
        return res;
    endfunction

    logic [7:0] inv_s;

    // Inversion followed by the affine transform.
    always_comb begin
        inv_s       = gf_inv(value);
        substituted = inv_s
                    ^ {inv_s[6:0], inv_s[7]}
                    ^ {inv_s[5:0], inv_s[7:6]}
                    ^ {inv_s[4:0], inv_s[7:5]}
                    ^ {inv_s[3:0], inv_s[7:4]}
                    ^ 8'h63;
    end

endmodule

// File: rtl/key_expansion.sv
// ----------------------------------------------------------------------------
// key_expansion -- AES-128 key schedule streaming one round key per cycle.
// A key accepted in IDLE is emitted as round 0 on the next cycle; each round
// key handshake advances to the next round until round 10 has been taken,
// after which the block returns to IDLE holding the last key on rk_out.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   key_in, key_valid     cipher key input (w0 = key_in[127:96])
//   key_ready             high in IDLE when not in reset
//   rk_out, rk_round      registered round key and its index 0..10
//   rk_valid, rk_ready    round-key handshake
//   busy                  high while emitting round keys
// Optional (macro AES_KEY_CACHE_EN):
//   cache_rd_addr         in  4   cache read address
//   cache_rd_data         out 128 cached round key (0 for addresses 11..15)
// ----------------------------------------------------------------------------
module key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
`ifdef AES_KEY_CACHE_EN
    ,
    input  logic [3:0]   cache_rd_addr,
    output logic [127:0] cache_rd_data
`endif
);

    ke_state_t  state_r, state_s;
    aes_block_t rk_out_r, rk_out_s;
    logic [3:0] rk_round_r, rk_round_s;
    logic       rk_valid_r, rk_valid_s;

    logic [31:0] rot_s;
    logic [31:0] sub_s;
    logic [31:0] temp_s;
    logic [31:0] w0_s, w1_s, w2_s;
    aes_block_t  next_key_s;

    // RotWord of w3; SubWord is done by the four S-box instances below.
    assign rot_s = {rk_out_r[23:0], rk_out_r[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .value       (rot_s[8*g +: 8]),
                .substituted (sub_s[8*g +: 8])
            );
        end
    endgenerate

    // Next round key from the current one (word chain w0'..w3').
    always_comb begin
        temp_s     = sub_s ^ {aes_rcon(rk_round_r + 4'd1), 24'h000000};
        w0_s       = rk_out_r[127:96] ^ temp_s;
        w1_s       = rk_out_r[95:64]  ^ w0_s;
        w2_s       = rk_out_r[63:32]  ^ w1_s;
        next_key_s = {w0_s, w1_s, w2_s, rk_out_r[31:0] ^ w2_s};
    end

    // FSM next-state and next register values.
    always_comb begin
        state_s    = state_r;
        rk_out_s   = rk_out_r;
        rk_round_s = rk_round_r;
        rk_valid_s = rk_valid_r;
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    state_s    = EMIT;
                    rk_out_s   = key_in;
                    rk_round_s = 4'd0;
                    rk_valid_s = 1'b1;
                end else begin
                    rk_valid_s = 1'b0;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rk_round_r < AES_ROUNDS) begin
                        rk_out_s   = next_key_s;
                        rk_round_s = rk_round_r + 4'd1;
                        rk_valid_s = 1'b1;
                    end else begin
                        // Last key consumed: keep rk_out/rk_round, drop valid.
                        state_s    = IDLE;
                        rk_valid_s = 1'b0;
                    end
                end else begin
                    rk_valid_s = 1'b1;
                end
            end
            default: begin
                state_s    = IDLE;
                rk_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rk_out_r   <= '0;
            rk_round_r <= 4'd0;
            rk_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rk_out_r   <= rk_out_s;
            rk_round_r <= rk_round_s;
            rk_valid_r <= rk_valid_s;
        end
    end

    assign key_ready = (state_r == IDLE) && !rst;
    assign busy      = (state_r == EMIT);
    assign rk_out    = rk_out_r;
    assign rk_round  = rk_round_r;
    assign rk_valid  = rk_valid_r;

`ifdef AES_KEY_CACHE_EN
    aes_block_t cache_r [0:10];

    // Capture every consumed round key at its round index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= 10; i++) begin
                cache_r[i] <= '0;
            end
        end else begin
            if (rk_valid_r && rk_ready && (rk_round_r <= AES_ROUNDS)) begin
                cache_r[rk_round_r] <= rk_out_r;
            end else begin
                cache_r[0] <= cache_r[0];
            end
        end
    end

    // Combinational cache read; unused addresses read as zero.
    always_comb begin
        cache_rd_data = '0;
        if (cache_rd_addr <= AES_ROUNDS) begin
            cache_rd_data = cache_r[cache_rd_addr];
        end else begin
            cache_rd_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_key_expansion.sv
// ----------------------------------------------------------------------------
// tb_key_expansion -- self-checking bench for key_expansion.
// Reference round keys come from a word-array FIPS-197 key schedule using an
// S-box table generated by the log/antilog walk over GF(2^8).
// ----------------------------------------------------------------------------
module tb_key_expansion;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
`ifdef AES_KEY_CACHE_EN
    logic [3:0]   cache_rd_addr;
    logic [127:0] cache_rd_data;
`endif

    key_expansion dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
`ifdef AES_KEY_CACHE_EN
        ,
        .cache_rd_addr (cache_rd_addr),
        .cache_rd_data (cache_rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] r1;
        logic [127:0] r10;
    } vec_t;

    vec_t         tbl [0:1];
    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk_exp [0:10];
    logic [127:0] got [0:10];
    int           checks;
    int           failures;
    int           last_cycles;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    // Full FIPS-197 schedule into rk_exp[0..10].
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
                    ^ {rcon, 24'h000000};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // mode 0: plain; 1: stall 3 cycles at round 4; 2: pulse another key at round 3.
    task automatic run_expansion(input logic [127:0] key, input int mode, input int stall_pct);
        int  budget;
        int  idx;
        int  stall_cnt;
        bit  pulsed;
        bit  rdy;
        model_expand(key);
        budget = 0;
        while (!key_ready && budget < 20) begin
            step();
            budget++;
        end
        check("key_ready_wait", {127'd0, key_ready}, 128'd1);
        key_in    = key;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        key_in    = ~key;
        idx = 0; stall_cnt = 0; pulsed = 1'b0; budget = 0; last_cycles = 0;
        while (idx < 11 && budget < 200) begin
            check("rk_valid", {127'd0, rk_valid}, 128'd1);
            check("rk_round", {124'd0, rk_round}, idx);
            check("rk_out", rk_out, rk_exp[idx]);
            check("busy_emit", {127'd0, busy}, 128'd1);
            check("key_ready_emit", {127'd0, key_ready}, 128'd0);
            got[idx] = rk_out;
            last_cycles++;
            rdy = 1'b1;
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) rdy = 1'b0;
            if (mode == 1 && idx == 4 && stall_cnt < 3) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            if (mode == 2 && idx == 3 && !pulsed) begin
                key_valid = 1'b1;
                key_in    = {$urandom, $urandom, $urandom, $urandom};
                pulsed    = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            rk_ready = rdy;
            step();
            if (rdy) idx++;
            budget++;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        check("expansion_done", idx, 11);
        check("idle_rk_valid", {127'd0, rk_valid}, 128'd0);
        check("idle_busy", {127'd0, busy}, 128'd0);
        check("idle_key_ready", {127'd0, key_ready}, 128'd1);
        check("held_round", {124'd0, rk_round}, 128'd10);
        check("held_out", rk_out, rk_exp[10]);
    endtask

    initial begin
        logic [127:0] k;
        int           budget;
        checks   = 0;
        failures = 0;
        tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'ha0fafe1788542cb123a339392a6c7605,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[1] = '{128'h0,
                   128'h62636363626363636263636362636363,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        build_sbox();
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
`ifdef AES_KEY_CACHE_EN
        cache_rd_addr = 4'd0;
`endif
        #3;
        check("rst_key_ready", {127'd0, key_ready}, 128'd0);
        check("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        check("rst_rk_round", {124'd0, rk_round}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_key_ready", {127'd0, key_ready}, 128'd1);

        // Known-answer vectors, rk_ready held high.
        for (int v = 0; v < 2; v++) begin
            run_expansion(tbl[v].key, 0, 0);
            check("kat_round0", got[0], tbl[v].key);
            check("kat_round1", got[1], tbl[v].r1);
            check("kat_round10", got[10], tbl[v].r10);
            check("kat_valid_cycles", last_cycles, 11);
`ifdef AES_KEY_CACHE_EN
            if (v == 0) begin
                cache_rd_addr = 4'd10;
                #1;
                check("cache_addr10", cache_rd_data, tbl[0].r10);
                cache_rd_addr = 4'd12;
                #1;
                check("cache_addr12", cache_rd_data, 128'd0);
            end
`endif
        end

        // Back-pressure at round 4.
        run_expansion({$urandom, $urandom, $urandom, $urandom}, 1, 0);
        check("stall_cycles", last_cycles, 14);

        // Key pulse during EMIT ignored, then a key right after round 10.
        run_expansion(tbl[0].key, 2, 0);
        run_expansion({$urandom, $urandom, $urandom, $urandom}, 0, 0);

        // Random keys with random back-pressure.
        for (int n = 0; n < 6; n++) begin
            run_expansion({$urandom, $urandom, $urandom, $urandom}, 0, 30);
        end

        // Reset mid-expansion at round 5.
        k = {$urandom, $urandom, $urandom, $urandom};
        key_in = k; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        budget = 0;
        while (rk_round != 4'd5 && budget < 20) begin
            step();
            budget++;
        end
        check("reach_round5", {124'd0, rk_round}, 128'd5);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rk_valid", {127'd0, rk_valid}, 128'd0);
        check("midrst_rk_out", rk_out, 128'd0);
        check("midrst_rk_round", {124'd0, rk_round}, 128'd0);
        check("midrst_busy", {127'd0, busy}, 128'd0);
        check("midrst_key_ready", {127'd0, key_ready}, 128'd0);
        step();
        rst = 1'b0;
        #1;
        check("after_rst_key_ready", {127'd0, key_ready}, 128'd1);
        for (int c = 0; c < 2; c++) begin
            step();
            check("after_rst_no_output", {127'd0, rk_valid}, 128'd0);
            check("after_rst_round", {124'd0, rk_round}, 128'd0);
        end
        rk_ready = 1'b0;
        run_expansion({$urandom, $urandom, $urandom, $urandom}, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: key_in  in  128  cipher key; word w0 = key_in[127:96].
REQ-004 SHALL have port: key_valid  in  1  key_in valid.
REQ-005 SHALL have port: key_ready  out  1  block accepts a new key.
REQ-006 SHALL have port: rk_out  out  128  current round key, same byte order as key_in.
REQ-007 SHALL have port: rk_round  out  4  round index of rk_out, 0..10.
REQ-008 SHALL have port: rk_valid  out  1  rk_out/rk_round valid.
REQ-009 SHALL have port: rk_ready  in  1  consumer (AddRoundKey stage) accepts the round key.
REQ-010 SHALL have port: busy  out  1  high in EMIT.

Function
REQ-011 SHALL implement FSM states IDLE and EMIT.
REQ-012 In IDLE, key_ready SHALL be 1 (0 while rst asserted); in EMIT, key_ready SHALL be 0 and key_valid is ignored.
REQ-013 On key_valid&&key_ready: next cycle EMIT, rk_out=key_in, rk_round=0, rk_valid=1 (latency 1 cycle).
REQ-014 rk_out, rk_round and rk_valid SHALL be registered and held stable while rk_valid&&!rk_ready.
REQ-015 On rk handshake with rk_round<10: next cycle rk_out=next round key, rk_round+1, rk_valid stays 1, giving one key per cycle under continuous rk_ready.
REQ-016 On rk handshake with rk_round==10: next cycle IDLE, rk_valid=0, rk_out/rk_round held.
REQ-017 Next key per FIPS-197: t=SubWord(RotWord(w3))^{Rcon,00,00,00}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-018 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36; the round counter never exceeds 10.
REQ-019 A key presented in the cycle after the round-10 handshake SHALL be accepted, with no dead cycle beyond the IDLE cycle.

Reset
REQ-020 rst SHALL act immediately: state IDLE, rk_out=0, rk_round=0, rk_valid=0, busy=0, internal counter=0.
REQ-021 rst mid-expansion SHALL abandon the key; no partial output after release.

Configuration
REQ-022 Macro AES_KEY_CACHE_EN defined: SHALL add ports cache_rd_addr in 4 and cache_rd_data out 128, plus an 11x128 register cache.
REQ-023 With AES_KEY_CACHE_EN, each rk handshake SHALL write rk_out to entry rk_round.
REQ-024 With AES_KEY_CACHE_EN, cache_rd_data SHALL be a combinational read of the cache; addresses 11..15 SHALL return 0; reset SHALL clear all entries.
REQ-025 Macro undefined: cache ports and storage SHALL be absent; behaviour is otherwise identical.

Structure
REQ-026 Shared package aes_pkg SHALL hold AES_ROUNDS=10, the Rcon table, the FSM state typedef and the 128-bit block typedef.
REQ-027 SubWord SHALL use sub-module aes_sbox (1-byte combinational S-box), instantiated 4x and shareable with the SubBytes stage.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round1 a0fafe1788542cb123a339392a6c7605, round10 d014f9a8c9ee2589e13f0cc8b6630ca6, 11 consecutive valid cycles.
REQ-029 Key all-zero -> round1 62636363626363636263636362636363, round10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 rk_ready low 3 cycles at rk_round=4 -> rk_out/rk_round stable, no skipped or repeated round.
REQ-031 key_valid pulsed with another key during EMIT -> ignored; sequence unchanged. Second key presented right after round 10 -> accepted and expanded correctly.
REQ-032 rst asserted at rk_round=5 -> outputs 0 in the same cycle; key_ready=1 after release; fresh key expands correctly.
REQ-033 With AES_KEY_CACHE_EN, after the REQ-028 run: cache_rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; cache_rd_addr=12 -> 0.
